// File: rtl/fifo_stream_reader.sv
// Consumer-side engine for a single-clock sync FIFO. On a start pulse it drains
// exactly xfer_len words from the FIFO read port and presents them on a valid/ready
// stream with an end-of-transfer marker. The FIFO's 1-cycle registered read latency
// is absorbed by a 2-entry output buffer, and no read is issued while the FIFO is empty.
module fifo_stream_reader #(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    xfer_len,
  output logic                busy,
  output logic                done,
  output logic                fifo_rd_en,
  input  logic                fifo_empty,
  input  logic                fifo_n_rd_en,
  input  logic [DATA_LEN-1:0] fifo_data,
  output logic [DATA_LEN-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    rd_left_q, rd_left_d;
  logic [LEN_W-1:0]    out_left_q, out_left_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_LEN-1:0] buf0_q, buf0_d;
  logic [DATA_LEN-1:0] buf1_q, buf1_d;

  logic       pop;
  logic [2:0] occ_after;

  // Stream outputs come straight from the buffer head register.
  always_comb begin
    m_valid = (occ_q != 2'd0);
    m_data  = buf0_q;
    m_last  = m_valid & (out_left_q == LEN_W'(1));
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  // Read issue: only when the word it returns next cycle is guaranteed a buffer slot.
  always_comb begin
    pop        = m_valid & m_ready;
    occ_after  = {1'b0, occ_q} + {2'b00, fifo_n_rd_en} - {2'b00, pop};
    fifo_rd_en = (state_q == StRun) & (rd_left_q != '0) & ~fifo_empty & (occ_after < 3'd2);
  end

  // Output buffer: entry 0 is the head; pop and capture together keep occupancy.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    unique case ({pop, fifo_n_rd_en})
      2'b01: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          buf1_d = fifo_data;
          occ_d  = 2'd2;
        end
      end
      2'b10: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  // Transfer counters and FSM next state.
  always_comb begin
    state_d    = state_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    if (fifo_rd_en) begin
      rd_left_d = rd_left_q - LEN_W'(1);
    end
    if (pop && (out_left_q != '0)) begin
      out_left_d = out_left_q - LEN_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_left_d  = xfer_len;
          out_left_d = xfer_len;
          state_d    = (xfer_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (fifo_rd_en && (rd_left_q == LEN_W'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Last word leaves this cycle: buffer empty and nothing in flight.
        if (out_left_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      rd_left_q  <= '0;
      out_left_q <= '0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural sync FIFO, in-order word scoreboard,
// directed timing scenarios and randomized transfers.
module tb_fifo_stream_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy, done, fifo_rd_en, fifo_empty, fifo_n_rd_en;
  logic [DW-1:0] fifo_data, m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_LEN(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .xfer_len    (xfer_len),
    .busy        (busy),
    .done        (done),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_empty  (fifo_empty),
    .fifo_n_rd_en(fifo_n_rd_en),
    .fifo_data   (fifo_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
  );

  // Behavioural FIFO with registered read data.
  logic [DW-1:0] fmem [256];
  logic [7:0]    fwp, frp;
  logic [8:0]    fcnt;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          frd;

  assign fifo_empty = (fcnt == 9'd0);
  assign frd        = fifo_rd_en && (fcnt != 9'd0);

  always_ff @(posedge clk) begin
    if (wr_en) fmem[fwp] <= wr_data;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fwp          <= '0;
      frp          <= '0;
      fcnt         <= '0;
      fifo_n_rd_en <= 1'b0;
      fifo_data    <= '0;
    end else begin
      fifo_n_rd_en <= frd;
      if (frd) begin
        fifo_data <= fmem[frp];
        frp       <= frp + 8'd1;
      end
      if (wr_en) fwp <= fwp + 8'd1;
      fcnt <= fcnt + 9'(wr_en) - 9'(frd);
    end
  end

  int total = 0;
  int bad = 0;
  int hcnt = 0;
  int cur_len = 0;
  int occ_m = 0;
  logic [DW-1:0] exp_q[$];
  bit stall_v = 1'b0;
  logic [DW-1:0] sv_data;
  logic sv_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Per-cycle checks: scoreboard, stall stability, read-while-empty, buffer overflow.
  task automatic mon();
    int nxt;
    logic [DW-1:0] w;
    if (!sys_rst_n) begin
      occ_m   = 0;
      stall_v = 1'b0;
      return;
    end
    if (start && !busy) begin
      cur_len = int'(xfer_len);
      hcnt    = 0;
    end
    chk("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
    chk("last_unqualified", 32'(m_last & ~m_valid), 0);
    nxt = occ_m + int'(fifo_n_rd_en) - int'(m_valid & m_ready);
    chk("buffer_overflow", 32'(nxt <= 2), 1);
    occ_m = nxt;
    if (stall_v) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", 32'(m_data), 32'(sv_data));
      chk("stall_last", 32'(m_last), 32'(sv_last));
    end
    stall_v = m_valid & ~m_ready;
    sv_data = m_data;
    sv_last = m_last;
    if (m_valid && m_ready) begin
      chk("sb_underflow", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_data", 32'(m_data), 32'(w));
      end
      chk("sb_last", 32'(m_last), 32'(hcnt + 1 == cur_len));
      hcnt++;
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic start_xfer(input int len);
    start    = 1'b1;
    xfer_len = LW'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (rnd) begin
        m_ready = 1'($urandom_range(0, 1));
        if (fcnt < 9'd240 && $urandom_range(0, 99) < 60) begin
          wr_en   = 1'b1;
          wr_data = DW'($urandom);
          exp_q.push_back(wr_data);
        end else begin
          wr_en = 1'b0;
        end
      end
      half();
      if (done) got = 1'b1;
      adv();
    end
    wr_en = 1'b0;
    chk(tag, 32'(got), 1);
  endtask

  initial begin
    int rds;
    int len;
    // Reset
    #1 sys_rst_n = 1'b0;
    exp_q.delete();
    adv();
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    sys_rst_n = 1'b1;
    cyc();

    // T2: back-to-back transfer timing
    for (int i = 0; i < 8; i++) push_word(DW'(8'h11 + i));
    cyc();
    start    = 1'b1;
    xfer_len = 8'd8;
    half();
    adv();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      half();
      chk("t2_rd_en", 32'(fifo_rd_en), 32'(c >= 1 && c <= 8));
      chk("t2_valid", 32'(m_valid), 32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("t2_data", 32'(m_data), 32'(8'h11 + c - 3));
      chk("t2_last", 32'(m_last), 32'(c == 10));
      chk("t2_done", 32'(done), 32'(c == 11));
      chk("t2_busy", 32'(busy), 32'(c <= 11));
      adv();
    end
    chk("t2_count", 32'(hcnt), 8);

    // T3: downstream stall
    for (int i = 0; i < 8; i++) push_word(DW'(8'h11 + i));
    cyc();
    start_xfer(8);
    rds = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) m_ready = 1'b0;
      half();
      rds += int'(fifo_rd_en);
      if (c == 12) begin
        chk("t3_rd_count", 32'(rds), 2);
        chk("t3_rd_low", 32'(fifo_rd_en), 0);
        chk("t3_hold_data", 32'(m_data), 32'h11);
        chk("t3_hold_valid", 32'(m_valid), 1);
      end
      adv();
    end
    m_ready = 1'b1;
    wait_done(100, 1'b0, "t3_done");
    chk("t3_count", 32'(hcnt), 8);

    // T4: FIFO runs dry mid-transfer
    for (int i = 0; i < 3; i++) push_word(DW'(8'h21 + i));
    start_xfer(6);
    for (int i = 0; i < 20; i++) cyc();
    chk("t4_stalled_busy", 32'(busy), 1);
    chk("t4_stalled_count", 32'(hcnt), 3);
    for (int i = 0; i < 3; i++) push_word(DW'(8'h24 + i));
    wait_done(100, 1'b0, "t4_done");
    chk("t4_count", 32'(hcnt), 6);

    // T5: zero-length transfer and ignored start while busy
    for (int i = 0; i < 4; i++) push_word(DW'(8'h31 + i));
    start    = 1'b1;
    xfer_len = 8'd0;
    half();
    adv();
    start = 1'b0;
    half();
    chk("t5_busy", 32'(busy), 1);
    chk("t5_done", 32'(done), 1);
    chk("t5_rd_en", 32'(fifo_rd_en), 0);
    adv();
    half();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_no_reads", 32'(fcnt), 4);
    adv();
    start_xfer(2);
    start_xfer(5);
    wait_done(50, 1'b0, "t5_done2");
    chk("t5_count", 32'(hcnt), 2);
    chk("t5_len", 32'(cur_len), 2);
    cyc();
    cyc();
    chk("t5_fifo_left", 32'(fcnt), 2);

    // T1: reset mid-stream, then a fresh 2-word transfer
    for (int i = 0; i < 4; i++) push_word(DW'(8'h41 + i));
    start_xfer(6);
    cyc();
    cyc();
    cyc();
    chk("t1_pre_valid", 32'(m_valid), 1);
    sys_rst_n = 1'b0;
    exp_q.delete();
    hcnt = 0;
    cur_len = 0;
    #1;
    chk("t1_valid", 32'(m_valid), 0);
    chk("t1_data", 32'(m_data), 0);
    chk("t1_last", 32'(m_last), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_rd_en", 32'(fifo_rd_en), 0);
    half();
    adv();
    sys_rst_n = 1'b1;
    cyc();
    chk("t1_no_done", 32'(done), 0);
    push_word(8'h51);
    push_word(8'h52);
    start_xfer(2);
    wait_done(50, 1'b0, "t1_done");
    chk("t1_count", 32'(hcnt), 2);

    // T6: randomized transfers with random backpressure and FIFO writes
    for (int t = 0; t < 200; t++) begin
      if (t == 0) len = 255;
      else if (t == 1) len = 1;
      else if (t % 10 == 5) len = int'($urandom_range(1, 255));
      else len = int'($urandom_range(1, 32));
      start_xfer(len);
      wait_done(len * 12 + 200, 1'b1, "t6_done");
      chk("t6_count", 32'(hcnt), 32'(len));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
